// File: rtl/booth4_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier sequencer.
package booth4_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 66;
  localparam int ACC_W  = 33;
  localparam int ITERS  = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Booth digit selected by one overlapping multiplier triple
  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } recode_e;

endpackage

// File: rtl/booth4_recode.sv
// Radix-4 modified-Booth recoder: maps the low triple of the product
// register onto the digit {0, +M, +2M, -M, -2M}.
module booth4_recode
  import booth4_pkg::*;
(
  input  logic [2:0] triple_i,
  output recode_e    code_o
);

  // pure table lookup, no state
  always_comb begin
    code_o = ZERO;
    unique case (triple_i)
      3'b001, 3'b010: code_o = PM;
      3'b011:         code_o = P2M;
      3'b100:         code_o = N2M;
      3'b101, 3'b110: code_o = NM;
      default:        code_o = ZERO;
    endcase
  end

endmodule

// File: rtl/booth4_mult_seq.sv
// Iterative radix-4 Booth signed multiplier: 16 recode/add/shift steps on a
// 66-bit product register, low 32 product bits presented with a one-cycle
// ready pulse. Overflow detection is built only when BOOTH4_OVERFLOW_EN is
// defined; otherwise overflow is tied low.
//
// state | meaning
// IDLE  | waiting for start, result/overflow hold last values
// RUN   | 16 Booth iterations, busy high
// DONE  | ready pulse, result valid
module booth4_mult_seq
  import booth4_pkg::*;
(
  input  logic            clock,
  input  logic            clr_n,
  input  logic            start,
  input  logic [OP_W-1:0] multiplicand,
  input  logic [OP_W-1:0] multiplier,
  output logic            busy,
  output logic            ready,
  output logic [OP_W-1:0] result,
  output logic            overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_e              state_q;
  logic [PROD_W-1:0]   p_q;
  logic [ACC_W:0]      m_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                ready_q;
  logic [OP_W-1:0]     result_q;

  recode_e             code;
  logic [ACC_W:0]      addend;
  logic [ACC_W:0]      sum34;
  logic [PROD_W-1:0]   p_d;

  booth4_recode u_recode (
    .triple_i (p_q[2:0]),
    .code_o   (code)
  );

  // select the Booth partial product; 2M still fits in 34 bits
  always_comb begin
    addend = '0;
    unique case (code)
      ZERO:    addend = '0;
      PM:      addend = m_q;
      P2M:     addend = {m_q[ACC_W-1:0], 1'b0};
      NM:      addend = -m_q;
      N2M:     addend = -{m_q[ACC_W-1:0], 1'b0};
      default: addend = '0;
    endcase
  end

  // accumulate in 34 bits, then arithmetic shift right by two
  always_comb begin
    sum34 = {p_q[PROD_W-1], p_q[PROD_W-1:OP_W+1]} + addend;
    p_d   = {sum34[ACC_W], sum34, p_q[OP_W:2]};
  end

`ifdef BOOTH4_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;

  // product bits 63..31 must all match the sign for a 32-bit fit
  always_comb begin
    ovf_d = (p_d[PROD_W-2:OP_W] != {ACC_W{p_d[PROD_W-2]}});
  end

  // overflow flag registered alongside the result
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST_CNT) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  // sequencer FSM with product, multiplicand, counter and registered outputs
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      p_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            p_q     <= {{ACC_W{1'b0}}, multiplier, 1'b0};
            m_q     <= {{2{multiplicand[OP_W-1]}}, multiplicand};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            result_q <= p_d[OP_W:1];
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: doc/booth4_mult_seq.md
# booth4_mult_seq

Iterative radix-4 modified-Booth signed multiplier sequencer for the processor's multiply/divide unit. It loads a 66-bit product/accumulator register from the operands and runs 16 recode/add/shift iterations. It then presents the low 32 bits of the 64-bit signed product, with an overflow flag, to the writeback mux. It is the control-and-datapath stage that drives the unit's 66-bit product register.

## Interface
- Parameters: none. Operand width is fixed at 32, product register at 66, iteration count at 16.
- clock  in  1  rising-edge clock
- clr_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- multiplicand  in  32  signed M, captured on accepted start
- multiplier  in  32  signed Q, captured on accepted start
- busy  out  1  high in RUN
- ready  out  1  single-cycle pulse; result valid
- result  out  32  product bits [31:0]
- overflow  out  1  64-bit product not representable in 32 signed bits

## Operation
- Product register P[65:0] layout: P[65:33] is the 33-bit signed accumulator, P[32:1] is Q, and P[0] is the Booth guard bit.
- M register is 34 bits, holding sign-extended M.
- On reset:
  - State is IDLE.
  - P, M and the 4-bit counter are 0.
  - busy, ready and overflow are 0; result is 0.
- In IDLE with start=1, at the next edge:
  - P = {33'b0, Q, 1'b0}, M = sext34(M), counter = 0.
  - State goes to RUN.
- In RUN, each edge:
  - Recode P[2:0]: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - sum34 = sext34(P[65:33]) + recoded value.
  - P ← ({sum34, P[32:0]} >>> 2)[65:0], an arithmetic shift.
  - The counter increments. On the edge where the counter equals 15, state goes to DONE.
- In DONE (one cycle):
  - ready=1.
  - result = P[32:1].
  - overflow = (P[64:32] not all-equal).
  - The next edge returns to IDLE.
- result and overflow hold their last values through IDLE until the next DONE.
- start asserted in RUN or DONE is ignored; it is not queued.
- start held high continuously starts a new operation on the first IDLE edge.
- Operand inputs are don't-care outside the accepting edge.

## Timing
- Accepting edge E0; iterations on E1..E16; ready high during the cycle following E16. Latency from start edge to ready is 17 cycles.
- Throughput is one operation per 18 cycles.
- busy is high from after E0 through E16 inclusive, and low in DONE and IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.
- clr_n low at any time, including mid-RUN or in DONE: immediate return to reset values. The first start is accepted on the first edge after clr_n deasserts.
- Corner case: M = Q = −2^31 gives product 2^62; the 33-bit accumulator never overflows, by the sum34 rule.

## Configuration
- BOOTH4_OVERFLOW_EN defined: overflow is computed and registered as above.
- BOOTH4_OVERFLOW_EN undefined: overflow is tied to 0 and the detection logic is absent. result is unchanged.

## Structure
- Shared package booth4_pkg holds:
  - the state enum: IDLE, RUN, DONE
  - the recode enum: ZERO, PM, P2M, NM, N2M
  - constants: OP_W=32, PROD_W=66, ACC_W=33, ITERS=16
- Sub-module booth4_recode: combinational; input 3-bit triple, output recode enum. The top level instantiates it once.
- The product register, M register, counter and FSM live in the top-level module.

## Test plan
- 3 × 5: start, then ready pulses exactly 17 cycles later with result=0x0000000F, overflow=0.
- −7 × 6: result=0xFFFFFFD6, overflow=0. busy is high for 16 cycles.
- 0x7FFFFFFF × 2: result=0xFFFFFFFE, overflow=1; with the macro undefined, overflow=0.
- 0x80000000 × 0xFFFFFFFF: result=0x80000000, overflow=1. Separately, 0x80000000 × 0x80000000: result=0, overflow=1.
- start pulsed again at iteration 5 with different operands: ignored; ready occurs once with the original result.
- clr_n low at iteration 8: all outputs go to 0 asynchronously. After release, 4 × −4 gives result=0xFFFFFFF0, overflow=0, 17 cycles after start.
